// File: rtl/matmul_seq.sv
// matmul_seq: sequential signed C = A*B, one multiply-accumulate per cycle, row-major valid/ready output.
// Optional MATMUL_SAT_EN: the output stage saturates to DATAWIDTH instead of wrapping.
module matmul_seq #(
    parameter int DATAWIDTH = 8,
    parameter int M         = 4,
    parameter int N         = 4,
    parameter int P         = 4,
    parameter int ACCWIDTH  = 2*DATAWIDTH+4,
    localparam int RW       = (M > 1) ? $clog2(M) : 1,
    localparam int CW       = (P > 1) ? $clog2(P) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [M*N*DATAWIDTH-1:0]  a_flat,
    input  logic [N*P*DATAWIDTH-1:0]  b_flat,
    output logic                      busy,
    output logic                      c_valid,
    input  logic                      c_ready,
    output logic [DATAWIDTH-1:0]      c_data,
    output logic [RW-1:0]             c_row,
    output logic [CW-1:0]             c_col,
    output logic                      c_last,
    output logic                      done
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0] IDX_LAST = IW'(N-1);
    localparam logic [RW-1:0] ROW_LAST = RW'(M-1);
    localparam logic [CW-1:0] COL_LAST = CW'(P-1);
    localparam logic signed [ACCWIDTH-1:0] SAT_MAX =
        {{(ACCWIDTH-DATAWIDTH+1){1'b0}}, {(DATAWIDTH-1){1'b1}}};
    localparam logic signed [ACCWIDTH-1:0] SAT_MIN =
        {{(ACCWIDTH-DATAWIDTH+1){1'b1}}, {(DATAWIDTH-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_MAC, S_OUT, S_DONE} state_t;

    state_t state_q, state_d;

    // Packed layout matches the flat buses element-for-element.
    logic [M-1:0][N-1:0][DATAWIDTH-1:0] a_q, a_d;
    logic [N-1:0][P-1:0][DATAWIDTH-1:0] b_q, b_d;

    logic [RW-1:0]               row_q, row_d;
    logic [CW-1:0]               col_q, col_d;
    logic [IW-1:0]               idx_q, idx_d;
    logic signed [ACCWIDTH-1:0]  acc_q, acc_d;

    logic                        c_valid_q, c_valid_d;
    logic [DATAWIDTH-1:0]        c_data_q, c_data_d;
    logic [RW-1:0]               c_row_q, c_row_d;
    logic [CW-1:0]               c_col_q, c_col_d;
    logic                        c_last_q, c_last_d;

    logic signed [DATAWIDTH-1:0]   a_el, b_el;
    logic signed [2*DATAWIDTH-1:0] prod;
    logic signed [ACCWIDTH-1:0]    acc_base, sum;
    logic [DATAWIDTH-1:0]          c_out;

    // Datapath: current product, running sum and its narrowed output form.
    always_comb begin
        a_el     = a_q[row_q][idx_q];
        b_el     = b_q[idx_q][col_q];
        prod     = a_el * b_el;
        acc_base = (idx_q == '0) ? '0 : acc_q;
        sum      = acc_base + ACCWIDTH'(prod);
`ifdef MATMUL_SAT_EN
        if (sum > SAT_MAX)
            c_out = SAT_MAX[DATAWIDTH-1:0];
        else if (sum < SAT_MIN)
            c_out = SAT_MIN[DATAWIDTH-1:0];
        else
            c_out = sum[DATAWIDTH-1:0];
`else
        c_out = sum[DATAWIDTH-1:0];
`endif
    end

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        row_d     = row_q;
        col_d     = col_q;
        idx_d     = idx_q;
        acc_d     = acc_q;
        c_valid_d = c_valid_q;
        c_data_d  = c_data_q;
        c_row_d   = c_row_q;
        c_col_d   = c_col_q;
        c_last_d  = c_last_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = a_flat;
                    b_d     = b_flat;
                    row_d   = '0;
                    col_d   = '0;
                    idx_d   = '0;
                    acc_d   = '0;
                    state_d = S_MAC;
                end
            end
            S_MAC: begin
                acc_d = sum;
                if (idx_q == IDX_LAST) begin
                    c_data_d  = c_out;
                    c_row_d   = row_q;
                    c_col_d   = col_q;
                    c_last_d  = (row_q == ROW_LAST) && (col_q == COL_LAST);
                    c_valid_d = 1'b1;
                    state_d   = S_OUT;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            S_OUT: begin
                if (c_ready) begin
                    c_valid_d = 1'b0;
                    if (c_last_q) begin
                        state_d = S_DONE;
                    end else begin
                        if (col_q == COL_LAST) begin
                            col_d = '0;
                            row_d = row_q + RW'(1);
                        end else begin
                            col_d = col_q + CW'(1);
                        end
                        idx_d   = '0;
                        state_d = S_MAC;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            a_q       <= '0;
            b_q       <= '0;
            row_q     <= '0;
            col_q     <= '0;
            idx_q     <= '0;
            acc_q     <= '0;
            c_valid_q <= 1'b0;
            c_data_q  <= '0;
            c_row_q   <= '0;
            c_col_q   <= '0;
            c_last_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            row_q     <= row_d;
            col_q     <= col_d;
            idx_q     <= idx_d;
            acc_q     <= acc_d;
            c_valid_q <= c_valid_d;
            c_data_q  <= c_data_d;
            c_row_q   <= c_row_d;
            c_col_q   <= c_col_d;
            c_last_q  <= c_last_d;
        end
    end

    assign busy    = (state_q != S_IDLE);
    assign done    = (state_q == S_DONE);
    assign c_valid = c_valid_q;
    assign c_data  = c_data_q;
    assign c_row   = c_row_q;
    assign c_col   = c_col_q;
    assign c_last  = c_last_q;

endmodule

// File: tb/tb_matmul_seq.sv
// Scoreboard bench for matmul_seq: integer reference model feeds an expected queue, a monitor checks each accepted element.
module tb_matmul_seq;

    localparam int DW = 8;
    localparam int TM = 2;
    localparam int TN = 2;
    localparam int TP = 2;
    localparam int AW = 2*DW+4;

    logic                  clk = 1'b0;
    logic                  rst = 1'b0;
    logic                  start = 1'b0;
    logic                  c_ready = 1'b0;
    logic [TM*TN*DW-1:0]   a_flat = '0;
    logic [TN*TP*DW-1:0]   b_flat = '0;
    logic                  busy, c_valid, c_last, done;
    logic [DW-1:0]         c_data;
    logic [$clog2(TM)-1:0] c_row;
    logic [$clog2(TP)-1:0] c_col;

    matmul_seq #(.DATAWIDTH(DW), .M(TM), .N(TN), .P(TP), .ACCWIDTH(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .a_flat(a_flat), .b_flat(b_flat),
        .busy(busy), .c_valid(c_valid), .c_ready(c_ready), .c_data(c_data),
        .c_row(c_row), .c_col(c_col), .c_last(c_last), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] data;
        int            row;
        int            col;
        bit            last;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   ja[TM][TN];
    int   jb[TN][TP];

    task automatic chk(input string name, input longint got, input longint expv);
        checks++;
        if (got != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, expv, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Output-stage rule: exact integer sum, then saturate or wrap to DW bits.
    function automatic logic [DW-1:0] out_stage(input int s);
        int v;
        v = s;
`ifdef MATMUL_SAT_EN
        if (v > (1 << (DW-1)) - 1) v = (1 << (DW-1)) - 1;
        else if (v < -(1 << (DW-1))) v = -(1 << (DW-1));
`endif
        return DW'(v);
    endfunction

    task automatic push_expected();
        exp_t e;
        int   s;
        for (int i = 0; i < TM; i++)
            for (int k = 0; k < TP; k++) begin
                s = 0;
                for (int j = 0; j < TN; j++) s += ja[i][j] * jb[j][k];
                e.data = out_stage(s);
                e.row  = i;
                e.col  = k;
                e.last = (i == TM-1) && (k == TP-1);
                sb_q.push_back(e);
            end
    endtask

    task automatic pack_inputs();
        for (int i = 0; i < TM; i++)
            for (int j = 0; j < TN; j++) a_flat[(i*TN+j)*DW +: DW] = DW'(ja[i][j]);
        for (int j = 0; j < TN; j++)
            for (int k = 0; k < TP; k++) b_flat[(j*TP+k)*DW +: DW] = DW'(jb[j][k]);
    endtask

    task automatic scramble_inputs();
        for (int i = 0; i < TM*TN; i++) a_flat[i*DW +: DW] = DW'($urandom);
        for (int i = 0; i < TN*TP; i++) b_flat[i*DW +: DW] = DW'($urandom);
    endtask

    task automatic rand_matrices();
        for (int i = 0; i < TM; i++)
            for (int j = 0; j < TN; j++) ja[i][j] = int'($urandom_range(0, 255)) - 128;
        for (int j = 0; j < TN; j++)
            for (int k = 0; k < TP; k++) jb[j][k] = int'($urandom_range(0, 255)) - 128;
    endtask

    // mode 0: ready high + cycle count; 1: random ready; 2: stall first element; 3: start held high.
    task automatic run_job(input int mode);
        int n, stall;
        bit got_done, released, chk_acc;
        push_expected();
        pack_inputs();
        start   = 1'b1;
        c_ready = (mode == 2) ? 1'b0 : 1'b1;
        tick();
        chk("busy_rise", busy, 1);
        start = (mode == 3);
        scramble_inputs();
        n = 0; stall = 0; got_done = 0; released = 0; chk_acc = 0;
        while (!got_done && n < 200) begin
            tick();
            n++;
            if (chk_acc) begin
                chk("bp_accept", c_valid, 0);
                chk_acc = 0;
            end
            if (done) begin
                got_done = 1;
            end else begin
                case (mode)
                    1: c_ready = 1'($urandom_range(0, 1));
                    2: if (c_valid && !released) begin
                        if (stall < 5) begin
                            chk("bp_valid", c_valid, 1);
                            if (sb_q.size() == 0) begin
                                chk("bp_queue", 0, 1);
                            end else begin
                                chk("bp_data", c_data, sb_q[0].data);
                                chk("bp_row", c_row, sb_q[0].row);
                                chk("bp_col", c_col, sb_q[0].col);
                            end
                            stall++;
                        end else begin
                            released = 1;
                            c_ready  = 1'b1;
                            chk_acc  = 1;
                        end
                    end
                    3: scramble_inputs();
                    default: ;
                endcase
            end
        end
        if (!got_done) begin
            checks++;
            errors++;
            $display("FAIL job_timeout: got no done after %0d cycles, required done", n);
        end
        if (mode == 0) chk("job_cycles", n + 1, TM*TP*(TN+1) + 1);
        chk("sb_drained", sb_q.size(), 0);
        chk("busy_in_done", busy, 1);
        c_ready = 1'($urandom_range(0, 1));
        tick();
        chk("done_pulse", done, 0);
        chk("busy_fall", busy, 0);
        start = 1'b0;
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_c_valid"}, c_valid, 0);
        chk({tag, "_c_data"}, c_data, 0);
        chk({tag, "_c_row"}, c_row, 0);
        chk({tag, "_c_col"}, c_col, 0);
        chk({tag, "_c_last"}, c_last, 0);
        chk({tag, "_done"}, done, 0);
    endtask

    always @(negedge clk) begin
        if (!rst && c_valid && c_ready) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_c: got data %0d row %0d col %0d, required no output",
                         c_data, c_row, c_col);
            end else begin
                mon_e = sb_q.pop_front();
                chk("c_data", c_data, mon_e.data);
                chk("c_row", c_row, mon_e.row);
                chk("c_col", c_col, mon_e.col);
                chk("c_last", c_last, mon_e.last);
            end
        end
    end

    initial begin
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_outputs_zero("reset");
        rst = 1'b0;
        tick();

        ja = '{'{1, 2}, '{3, 4}};
        jb = '{'{1, 0}, '{0, 1}};
        run_job(0);

        ja = '{'{-3, 5}, '{7, -2}};
        jb = '{'{2, -1}, '{4, 6}};
        run_job(0);

        rand_matrices();
        run_job(2);

        ja = '{'{127, 127}, '{127, 127}};
        jb = '{'{127, 127}, '{127, 127}};
        run_job(1);

        rand_matrices();
        push_expected();
        pack_inputs();
        start   = 1'b1;
        c_ready = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        chk("mid_busy", busy, 1);
        rst = 1'b1;
        #1;
        chk_outputs_zero("mid_rst");
        sb_q.delete();
        tick();
        rst = 1'b0;
        rand_matrices();
        run_job(0);

        rand_matrices();
        run_job(3);
        rand_matrices();
        run_job(0);

        for (int t = 0; t < 8; t++) begin
            rand_matrices();
            run_job(int'($urandom_range(0, 3)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
